// File: rtl/ex_pkg.sv
// Shared types for the ID/EX issue stage: forwarding select and stored payload.
package ex_pkg;

  localparam int EX_XLEN   = 32;
  localparam int EX_REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_ZERO = 2'd0,
    FWD_EXM  = 2'd1,
    FWD_MWB  = 2'd2,
    FWD_RF   = 2'd3
  } fwd_sel_e;

  // Everything the stage keeps while an instruction is held. Source register
  // indices are kept so operands can be refreshed during a stall.
  typedef struct packed {
    logic [3:0]           alu_op;
    logic [EX_XLEN-1:0]   pc;
    logic [EX_XLEN-1:0]   imm;
    logic [EX_XLEN-1:0]   rs1_val;
    logic [EX_XLEN-1:0]   rs2_val;
    logic [EX_REG_AW-1:0] rs1_addr;
    logic [EX_REG_AW-1:0] rs2_addr;
    logic [EX_REG_AW-1:0] rd_addr;
    logic                 rd_we;
    logic                 use_pc_a;
    logic                 use_imm_b;
  } id_ex_t;

endpackage

// File: rtl/ex_issue_stage_operand_fwd_sel.sv
// Priority resolver for one source operand: x0, then EX/MEM, then MEM/WB,
// otherwise the fallback value (register-file data or the held value).
module operand_fwd_sel
  import ex_pkg::*;
#(
  parameter int XLEN   = EX_XLEN,
  parameter int REG_AW = EX_REG_AW
) (
  input  logic [REG_AW-1:0] i_rs_addr,
  input  logic [XLEN-1:0]   i_rf_data,
  input  logic              i_exm_we,
  input  logic [REG_AW-1:0] i_exm_rd,
  input  logic [XLEN-1:0]   i_exm_data,
  input  logic              i_mwb_we,
  input  logic [REG_AW-1:0] i_mwb_rd,
  input  logic [XLEN-1:0]   i_mwb_data,
  output logic [XLEN-1:0]   o_data
);

  fwd_sel_e w_sel;

  // Pick the source; EX/MEM is younger than MEM/WB so it wins on a tie.
  always_comb begin
    w_sel = FWD_RF;
    if (i_rs_addr == '0)                              w_sel = FWD_ZERO;
    else if (i_exm_we && (i_exm_rd == i_rs_addr))     w_sel = FWD_EXM;
    else if (i_mwb_we && (i_mwb_rd == i_rs_addr))     w_sel = FWD_MWB;
  end

  // Route the selected source to the output.
  always_comb begin
    o_data = i_rf_data;
    case (w_sel)
      FWD_ZERO: o_data = '0;
      FWD_EXM:  o_data = i_exm_data;
      FWD_MWB:  o_data = i_mwb_data;
      default:  o_data = i_rf_data;
    endcase
  end

endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX issue stage: single-entry holding register in front of the ALU with
// capture-time forwarding and operand refresh while stalled.
module ex_issue_stage
  import ex_pkg::*;
#(
  parameter int XLEN   = EX_XLEN,
  parameter int REG_AW = EX_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_alu_op,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [REG_AW-1:0] in_rs1_addr,
  input  logic [REG_AW-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [REG_AW-1:0] in_rd_addr,
  input  logic              in_rd_we,
  input  logic              in_use_pc_a,
  input  logic              in_use_imm_b,
  input  logic              exm_we,
  input  logic [REG_AW-1:0] exm_rd,
  input  logic [XLEN-1:0]   exm_data,
  input  logic              mwb_we,
  input  logic [REG_AW-1:0] mwb_rd,
  input  logic [XLEN-1:0]   mwb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        alu_op,
  output logic [XLEN-1:0]   operand_a,
  output logic [XLEN-1:0]   operand_b,
  output logic [REG_AW-1:0] out_rd_addr,
  output logic              out_rd_we,
  output logic [XLEN-1:0]   out_pc
);

  logic              r_valid;
  id_ex_t            r_ex;
  logic              w_capture;
  logic              w_refresh;
  logic [XLEN-1:0]   w_rs1_cap;
  logic [XLEN-1:0]   w_rs2_cap;
  logic [XLEN-1:0]   w_rs1_ref;
  logic [XLEN-1:0]   w_rs2_ref;

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;
  assign w_refresh = r_valid && !out_ready;

  // Capture-time resolution uses the incoming register-file data as fallback.
  operand_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs1_cap (
    .i_rs_addr (in_rs1_addr), .i_rf_data (in_rs1_data),
    .i_exm_we  (exm_we),      .i_exm_rd  (exm_rd),      .i_exm_data (exm_data),
    .i_mwb_we  (mwb_we),      .i_mwb_rd  (mwb_rd),      .i_mwb_data (mwb_data),
    .o_data    (w_rs1_cap)
  );

  operand_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs2_cap (
    .i_rs_addr (in_rs2_addr), .i_rf_data (in_rs2_data),
    .i_exm_we  (exm_we),      .i_exm_rd  (exm_rd),      .i_exm_data (exm_data),
    .i_mwb_we  (mwb_we),      .i_mwb_rd  (mwb_rd),      .i_mwb_data (mwb_data),
    .o_data    (w_rs2_cap)
  );

  // Refresh resolution falls back to the held value, so no hit means no change.
  operand_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs1_ref (
    .i_rs_addr (r_ex.rs1_addr), .i_rf_data (r_ex.rs1_val),
    .i_exm_we  (exm_we),        .i_exm_rd  (exm_rd),      .i_exm_data (exm_data),
    .i_mwb_we  (mwb_we),        .i_mwb_rd  (mwb_rd),      .i_mwb_data (mwb_data),
    .o_data    (w_rs1_ref)
  );

  operand_fwd_sel #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rs2_ref (
    .i_rs_addr (r_ex.rs2_addr), .i_rf_data (r_ex.rs2_val),
    .i_exm_we  (exm_we),        .i_exm_rd  (exm_rd),      .i_exm_data (exm_data),
    .i_mwb_we  (mwb_we),        .i_mwb_rd  (mwb_rd),      .i_mwb_data (mwb_data),
    .o_data    (w_rs2_ref)
  );

  // Valid flag: flush kills, capture sets, consume without capture clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload: load on capture, otherwise refresh forwarded operands while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (w_capture) begin
      r_ex.alu_op    <= in_alu_op;
      r_ex.pc        <= in_pc;
      r_ex.imm       <= in_imm;
      r_ex.rs1_val   <= w_rs1_cap;
      r_ex.rs2_val   <= w_rs2_cap;
      r_ex.rs1_addr  <= in_rs1_addr;
      r_ex.rs2_addr  <= in_rs2_addr;
      r_ex.rd_addr   <= in_rd_addr;
      r_ex.rd_we     <= in_rd_we;
      r_ex.use_pc_a  <= in_use_pc_a;
      r_ex.use_imm_b <= in_use_imm_b;
    end else if (w_refresh) begin
      r_ex.rs1_val   <= w_rs1_ref;
      r_ex.rs2_val   <= w_rs2_ref;
    end
  end

  assign out_valid   = r_valid;
  assign alu_op      = r_ex.alu_op;
  assign operand_a   = r_ex.use_pc_a  ? r_ex.pc  : r_ex.rs1_val;
  assign operand_b   = r_ex.use_imm_b ? r_ex.imm : r_ex.rs2_val;
  assign out_rd_addr = r_ex.rd_addr;
  assign out_rd_we   = r_ex.rd_we;
  assign out_pc      = r_ex.pc;

endmodule

// File: tb/tb_ex_issue_stage.sv
// Self-checking bench for ex_issue_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_ex_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_alu_op;
  logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic        in_rd_we, in_use_pc_a, in_use_imm_b;
  logic        exm_we, mwb_we;
  logic [4:0]  exm_rd, mwb_rd;
  logic [31:0] exm_data, mwb_data;
  logic        flush, out_valid, out_ready;
  logic [3:0]  alu_op;
  logic [31:0] operand_a, operand_b, out_pc;
  logic [4:0]  out_rd_addr;
  logic        out_rd_we;

  int n_chk = 0;
  int n_err = 0;

  // Opcode used for the ADD scenario; the stage treats alu_op as opaque.
  logic [3:0] add_op;

  // Behavioural model of what the stage is holding.
  typedef struct {
    bit          valid;
    logic [3:0]  op;
    logic [31:0] pc, imm, v1, v2;
    logic [4:0]  a1, a2, rd;
    logic        we, upc, uimm;
  } held_t;
  held_t m;

  ex_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_rd_addr(in_rd_addr), .in_rd_we(in_rd_we),
    .in_use_pc_a(in_use_pc_a), .in_use_imm_b(in_use_imm_b),
    .exm_we(exm_we), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_we(mwb_we), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Value a source register reads as, given the forwarding network right now.
  function automatic logic [31:0] resolve(input logic [4:0] a, input logic [31:0] fallback);
    if (a == 5'd0) return 32'd0;
    if (exm_we && exm_rd == a) return exm_data;
    if (mwb_we && mwb_rd == a) return mwb_data;
    return fallback;
  endfunction

  task automatic idle_inputs();
    in_valid = 0; in_alu_op = 0; in_pc = 0; in_imm = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
    in_rd_addr = 0; in_rd_we = 0; in_use_pc_a = 0; in_use_imm_b = 0;
    exm_we = 0; exm_rd = 0; exm_data = 0; mwb_we = 0; mwb_rd = 0; mwb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  task automatic model_reset();
    m = '{default: '0};
  endtask

  task automatic compare_outputs();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m.valid});
    if (m.valid) begin
      chk("alu_op",      {28'd0, alu_op}, {28'd0, m.op});
      chk("operand_a",   operand_a, m.upc  ? m.pc  : m.v1);
      chk("operand_b",   operand_b, m.uimm ? m.imm : m.v2);
      chk("out_rd_addr", {27'd0, out_rd_addr}, {27'd0, m.rd});
      chk("out_rd_we",   {31'd0, out_rd_we}, {31'd0, m.we});
      chk("out_pc",      out_pc, m.pc);
    end
  endtask

  // One clock: inputs already driven while clk is low. Checks in_ready, advances
  // the model with the rules of the stage, then checks outputs on the falling edge.
  task automatic step();
    held_t nx;
    bit    rdy;
    #1;
    rdy = !m.valid || out_ready;
    chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    nx = m;
    if (flush) begin
      nx.valid = 0;
    end else if (in_valid && rdy) begin
      nx.valid = 1; nx.op = in_alu_op; nx.pc = in_pc; nx.imm = in_imm;
      nx.a1 = in_rs1_addr; nx.a2 = in_rs2_addr;
      nx.v1 = resolve(in_rs1_addr, in_rs1_data);
      nx.v2 = resolve(in_rs2_addr, in_rs2_data);
      nx.rd = in_rd_addr; nx.we = in_rd_we; nx.upc = in_use_pc_a; nx.uimm = in_use_imm_b;
    end else if (m.valid && out_ready) begin
      nx.valid = 0;
    end else if (m.valid) begin
      nx.v1 = resolve(m.a1, m.v1);
      nx.v2 = resolve(m.a2, m.v2);
    end
    @(posedge clk);
    m = nx;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a2, input logic [31:0] d2);
    in_valid = 1; in_alu_op = op; in_pc = pc; in_imm = 0;
    in_rs1_addr = a1; in_rs1_data = d1; in_rs2_addr = a2; in_rs2_data = d2;
    in_rd_addr = 5'd10; in_rd_we = 1; in_use_pc_a = 0; in_use_imm_b = 0;
  endtask

  initial begin
    add_op = 4'h0;
    idle_inputs();
    model_reset();
    rst_n = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1;
    // Reset state
    chk("rst in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst operand_a", operand_a, 32'd0);
    chk("rst operand_b", operand_b, 32'd0);
    chk("rst alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst out_pc", out_pc, 32'd0);
    chk("rst rd", {26'd0, out_rd_we, out_rd_addr}, 32'd0);

    // Simple capture
    issue(add_op, 32'h40, 5'd1, 32'd5, 5'd2, 32'd7);
    step();
    chk("add valid", {31'd0, out_valid}, 32'd1);
    chk("add a", operand_a, 32'd5);
    chk("add b", operand_b, 32'd7);
    chk("add op", {28'd0, alu_op}, {28'd0, add_op});

    // Forward priority: EX/MEM beats MEM/WB beats RF
    issue(4'h3, 32'h44, 5'd3, 32'h11, 5'd0, 32'h55);
    exm_we = 1; exm_rd = 5'd3; exm_data = 32'hAA;
    mwb_we = 1; mwb_rd = 5'd3; mwb_data = 32'hBB;
    step();
    chk("fwd exm wins", operand_a, 32'hAA);
    chk("fwd x0 b", operand_b, 32'd0);
    in_rs1_addr = 5'd0; in_pc = 32'h48;
    step();
    chk("fwd x0 a", operand_a, 32'd0);
    exm_we = 0; mwb_we = 0;

    // Stall with refresh through MEM/WB
    issue(4'h1, 32'h4C, 5'd0, 32'd0, 5'd4, 32'd1);
    step();
    chk("stall cap b", operand_b, 32'd1);
    in_valid = 0; out_ready = 0;
    step();
    chk("stall in_ready", {31'd0, in_ready}, 32'd0);
    mwb_we = 1; mwb_rd = 5'd4; mwb_data = 32'd9;
    step();
    chk("refresh b", operand_b, 32'd9);
    chk("refresh hold", {31'd0, out_valid}, 32'd1);
    mwb_we = 0;
    step();
    chk("refresh keep", operand_b, 32'd9);
    chk("stall in_ready2", {31'd0, in_ready}, 32'd0);
    out_ready = 1;

    // Back-to-back throughput
    for (int i = 0; i < 4; i++) begin
      issue(4'h2, 32'h200 + 32'(i * 4), 5'd5, 32'(i), 5'd6, 32'(i + 100));
      step();
      chk("b2b pc", out_pc, 32'h200 + 32'(i * 4));
      chk("b2b a", operand_a, 32'(i));
    end

    // Flush with simultaneous input drops it
    issue(4'h5, 32'h300, 5'd1, 32'd1, 5'd2, 32'd2);
    flush = 1;
    step();
    chk("flush valid", {31'd0, out_valid}, 32'd0);
    flush = 0; in_valid = 0;
    step();
    chk("flush dropped", {31'd0, out_valid}, 32'd0);

    // PC / immediate select
    issue(4'h0, 32'h100, 5'd7, 32'h77, 5'd8, 32'h88);
    in_use_pc_a = 1; in_use_imm_b = 1; in_imm = 32'hFFFFFFFC;
    step();
    chk("sel a pc", operand_a, 32'h100);
    chk("sel b imm", operand_b, 32'hFFFFFFFC);

    // Async reset while holding
    in_valid = 0; out_ready = 0;
    step();
    #2 rst_n = 0;
    #1;
    chk("async out_valid", {31'd0, out_valid}, 32'd0);
    chk("async a", operand_a, 32'd0);
    chk("async b", operand_b, 32'd0);
    chk("async pc", out_pc, 32'd0);
    chk("async in_ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1;

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      in_valid     = ($urandom_range(0, 9) < 7);
      in_alu_op    = 4'($urandom);
      in_pc        = $urandom;
      in_imm       = $urandom;
      in_rs1_addr  = 5'($urandom_range(0, 7));
      in_rs2_addr  = 5'($urandom_range(0, 7));
      in_rs1_data  = $urandom;
      in_rs2_data  = $urandom;
      in_rd_addr   = 5'($urandom);
      in_rd_we     = 1'($urandom);
      in_use_pc_a  = ($urandom_range(0, 3) == 0);
      in_use_imm_b = ($urandom_range(0, 3) == 0);
      exm_we       = 1'($urandom);
      exm_rd       = 5'($urandom_range(0, 7));
      exm_data     = $urandom;
      mwb_we       = 1'($urandom);
      mwb_rd       = 5'($urandom_range(0, 7));
      mwb_data     = $urandom;
      flush        = ($urandom_range(0, 19) == 0);
      out_ready    = ($urandom_range(0, 9) < 6);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ex_issue_stage.md
# ex_issue_stage

ID/EX pipeline stage that sits directly upstream of the ALU. It accepts a decoded instruction from decode over a valid/ready handshake and resolves rs1/rs2 through EX/MEM and MEM/WB forwarding. It holds the instruction in a single-entry register and presents the selected `operand_a`/`operand_b`/`alu_op` to the ALU. It also supports stall back-pressure, pipeline flush, and operand refresh while an instruction is held.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `REG_AW`, 5, register address width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `in_alu_op`  in  4  ALU operation, `ALU_OP_*` encoding
- `in_pc`  in  XLEN  instruction PC
- `in_imm`  in  XLEN  sign-extended immediate
- `in_rs1_addr`, `in_rs2_addr`  in  REG_AW  source register indices
- `in_rs1_data`, `in_rs2_data`  in  XLEN  register-file read data
- `in_rd_addr`  in  REG_AW  destination index
- `in_rd_we`  in  1  instruction writes rd
- `in_use_pc_a`  in  1  operand_a = pc instead of rs1
- `in_use_imm_b`  in  1  operand_b = imm instead of rs2
- `exm_we`, `exm_rd`, `exm_data`  in  1/REG_AW/XLEN  EX/MEM forwarding source
- `mwb_we`, `mwb_rd`, `mwb_data`  in  1/REG_AW/XLEN  MEM/WB forwarding source
- `flush`  in  1  kill held and incoming instruction
- `out_valid`  out  1  ALU inputs valid
- `out_ready`  in  1  downstream consumes this cycle
- `alu_op`  out  4  to ALU
- `operand_a`, `operand_b`  out  XLEN  to ALU
- `out_rd_addr`  out  REG_AW
- `out_rd_we`  out  1
- `out_pc`  out  XLEN

## Operation
- Single entry register.
  - `in_ready = !out_valid || out_ready`, purely combinational.
  - Capture occurs when `in_valid && in_ready && !flush`.
- Forwarding on capture, per source `rsN`, highest priority first:
  - `rsN == 0` → 0.
  - `exm_we && exm_rd == rsN` → `exm_data`.
  - `mwb_we && mwb_rd == rsN` → `mwb_data`.
  - Otherwise `in_rsN_data`.
- Held refresh:
  - Applies when `out_valid && !out_ready`.
  - Each cycle, stored `rsN_val` is overwritten using the same priority: EX/MEM, then MEM/WB, never for x0.
  - Stored rs addresses are kept for this purpose.
- Output selection, combinational from stored state:
  - `operand_a = use_pc_a ? pc : rs1_val`.
  - `operand_b = use_imm_b ? imm : rs2_val`.
  - The refresh rule also applies when `use_imm_b` is set. It is harmless because `operand_b` shows `imm`.
- `flush` has priority over everything.
  - Next cycle `out_valid = 0`.
  - A simultaneous input is dropped, even if `in_valid && in_ready`.
- Simultaneous capture and consume (`out_valid && out_ready && in_valid`): the new instruction replaces the old one in the same edge, giving full throughput.
- Consume without new input: `out_valid` clears.
- Payload registers update only on capture or refresh. Their content is don't-care while `out_valid = 0`.

## Timing
- Latency is 1 cycle from accepted input to `out_valid`.
- `operand_a`/`operand_b` respond combinationally to stored state only. There is no combinational path from the forwarding inputs to the outputs.
- Refreshed values appear the cycle after the forwarding source asserts.
- Reset (async assert, sync deassert by the system):
  - `out_valid = 0`.
  - Every payload register = 0, so `alu_op = 0`, operands = 0, `out_rd_we = 0`, `out_rd_addr = 0`, `out_pc = 0`.
  - `in_ready = 1`.
- Reset asserted mid-hold discards the instruction immediately, without waiting for a clock edge.
- Both forwarding sources match the same register: EX/MEM wins.

## Structure
- Shared package `ex_pkg`:
  - `fwd_sel_e` enum: `FWD_ZERO`, `FWD_EXM`, `FWD_MWB`, `FWD_RF`.
  - `id_ex_t` struct holding the stored payload.
- ALU op encodings come from the existing common defines header (`ALU_OP_*`). Do not redefine them.
- One sub-module, `operand_fwd_sel`:
  - Combinational priority resolver per source.
  - Instantiated 4×: rs1 and rs2, each for capture and for refresh.

## Test plan
- Reset then idle:
  - `rst_n` low mid-cycle → `out_valid = 0` and all outputs 0 immediately.
  - After release, `in_ready = 1`.
- Simple capture: ADD with rs1=x1 (data 5), rs2=x2 (data 7), `out_ready = 1` → next cycle `out_valid = 1`, `operand_a = 5`, `operand_b = 7`, `alu_op = ALU_OP_ADD`.
- Forward priority: rs1 = x3, `exm_rd = 3`/`exm_data = 0xAA`, `mwb_rd = 3`/`mwb_data = 0xBB`, rf = 0x11 → `operand_a = 0xAA`. With rs1 = x0 and the same sources → `operand_a = 0`.
- Stall with refresh:
  - Capture with rs2 = x4 (rf 1) and hold `out_ready = 0`.
  - Then pulse `mwb_we`, `mwb_rd = 4`, `mwb_data = 9` → `operand_b = 9` next cycle.
  - `in_ready = 0` throughout the stall.
- Throughput and flush:
  - Back-to-back valid inputs with `out_ready = 1` → one output per cycle, in order.
  - `flush` together with `in_valid` → `out_valid = 0` next cycle and the input is dropped.
- Immediate/PC select: `use_pc_a = 1`, `use_imm_b = 1`, pc = 0x100, imm = 0xFFFFFFFC → `operand_a = 0x100`, `operand_b = 0xFFFFFFFC`.
